// File: rtl/vec_lsu.sv
// vec_lsu: vector load/store unit sequencing one request over NLANES DMEM word ports.
// Ports: req_* request, mem_* DMEM lanes, done_* completion, busy; option VLSU_MISALIGN_TRAP_EN.
module vec_lsu #(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int NLANES = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_store,
  input  logic [1:0]                     req_mode,
  input  logic [XLEN-1:0]                req_base,
  input  logic [XLEN-1:0]                req_stride,
  input  logic [VLEN-1:0]                req_index,
  input  logic [$clog2(VLEN/32):0]       req_vl,
  input  logic [VLEN/32-1:0]             req_mask,
  input  logic [VLEN-1:0]                req_data,
  output logic [NLANES-1:0]              mem_we,
  output logic [NLANES-1:0]              mem_re,
  output logic [NLANES*ADDR_WIDTH-1:0]   mem_addr,
  output logic [NLANES*32-1:0]           mem_wdata,
  input  logic [NLANES*32-1:0]           mem_rdata,
  output logic                           done_valid,
  input  logic                           done_ready,
  output logic [VLEN-1:0]                done_data,
  output logic                           done_err,
  output logic                           busy
);

  localparam int NELEM = VLEN / 32;
  localparam int EW = $clog2(NELEM);
  localparam int VW = EW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic                storeReg;
  logic [1:0]          modeReg;
  logic [XLEN-1:0]     baseReg;
  logic [XLEN-1:0]     strideReg;
  logic [VLEN-1:0]     indexReg;
  logic [VW-1:0]       vlReg;
  logic [NELEM-1:0]    maskReg;
  logic [VLEN-1:0]     resultReg;
  logic [EW-1:0]       beatReg;
  logic [EW-1:0]       lastBeat;
  logic [EW-1:0]       pendBeat;
  logic [NLANES-1:0]   rdPend;
  logic                errReg;

  logic [VW-1:0]       vlClamp;
  logic [EW-1:0]       lastNext;
  logic [EW-1:0]       laneEl [NLANES];
  logic [EW-1:0]       pendEl [NLANES];
  logic [XLEN-1:0]     laneAddr [NLANES];
  logic [NLANES-1:0]   laneAct;
  logic                abort;
  logic                issueOn;
  logic                unusedHi;

  always_comb begin
    vlClamp = (req_vl > VW'(NELEM)) ? VW'(NELEM) : req_vl;
    lastNext = EW'((int'(vlClamp) + NLANES - 1) / NLANES - 1);
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      laneEl[l] = EW'(int'(beatReg) * NLANES + l);
      pendEl[l] = EW'(int'(pendBeat) * NLANES + l);
      unique case (modeReg)
        2'd1:    laneAddr[l] = baseReg + XLEN'(laneEl[l]) * strideReg;
        2'd2:    laneAddr[l] = baseReg + XLEN'(indexReg[32*laneEl[l] +: 32]);
        default: laneAddr[l] = baseReg + (XLEN'(laneEl[l]) << 2);
      endcase
      laneAct[l] = ({1'b0, laneEl[l]} < vlReg) && maskReg[laneEl[l]];
    end
  end

  assign issueOn = (state == S_ISSUE);

`ifdef VLSU_MISALIGN_TRAP_EN
  logic [NLANES-1:0] laneMis;
  always_comb begin
    for (int l = 0; l < NLANES; l++)
      laneMis[l] = laneAct[l] && (laneAddr[l][1:0] != 2'b00);
    abort = issueOn && (|laneMis);
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    mem_we = '0;
    mem_re = '0;
    mem_addr = '0;
    mem_wdata = '0;
    unusedHi = 1'b0;
    for (int l = 0; l < NLANES; l++) begin
      unusedHi = unusedHi ^ (^laneAddr[l][XLEN-1:ADDR_WIDTH]);
      if (issueOn) begin
        mem_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = laneAddr[l][ADDR_WIDTH-1:0];
        mem_wdata[l*32 +: 32] = resultReg[32*laneEl[l] +: 32];
      end
    end
    if (issueOn && !abort) begin
      if (storeReg) mem_we = laneAct;
      else          mem_re = laneAct;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      storeReg  <= 1'b0;
      modeReg   <= '0;
      baseReg   <= '0;
      strideReg <= '0;
      indexReg  <= '0;
      vlReg     <= '0;
      maskReg   <= '0;
      resultReg <= '0;
      beatReg   <= '0;
      lastBeat  <= '0;
      pendBeat  <= '0;
      rdPend    <= '0;
      errReg    <= 1'b0;
    end else begin
      // load data arrives one cycle after its beat was issued
      for (int l = 0; l < NLANES; l++)
        if (rdPend[l])
          resultReg[32*pendEl[l] +: 32] <= mem_rdata[32*l +: 32];
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            storeReg  <= req_store;
            modeReg   <= req_mode;
            baseReg   <= req_base;
            strideReg <= req_stride;
            indexReg  <= req_index;
            vlReg     <= vlClamp;
            maskReg   <= req_mask;
            resultReg <= req_data;
            beatReg   <= '0;
            lastBeat  <= lastNext;
            rdPend    <= '0;
            errReg    <= 1'b0;
            state     <= (vlClamp == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          pendBeat <= beatReg;
          rdPend   <= (storeReg || abort) ? '0 : laneAct;
          if (abort) begin
            errReg <= 1'b1;
            state  <= storeReg ? S_DONE : S_WAIT;
          end else if (beatReg == lastBeat) begin
            state  <= storeReg ? S_DONE : S_WAIT;
          end else begin
            beatReg <= beatReg + EW'(1);
          end
        end
        S_WAIT: begin
          rdPend <= '0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (done_ready) state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done_valid = (state == S_DONE);
  assign done_data  = resultReg;
  assign done_err   = errReg;

endmodule
